// File: rtl/sr_readback_rx.sv
// Multi-channel shift-register readback receiver.
// After an accepted start and an optional 0-3 cycle delay, it samples NCH
// serial lines for L bits per frame. The captured frame is then published on
// dout with a one-cycle valid pulse.
module sr_readback_rx #(
   parameter int unsigned DATA_WIDTH      = 170,
   parameter int unsigned NCH             = 4,
   parameter int unsigned CNT_WIDTH       = 8,
   parameter bit          SHIFT_DIRECTION = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [1:0]                delay,
   input  logic [CNT_WIDTH-1:0]      len,
   input  logic [NCH-1:0]            data_in,
   output logic [NCH*DATA_WIDTH-1:0] dout,
   output logic                      valid,
   output logic                      busy,
   output logic                      overrun,
   output logic [CNT_WIDTH-1:0]      bit_cnt
);

   localparam logic [CNT_WIDTH-1:0] DW_C = CNT_WIDTH'(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                             state_q;
   logic [1:0]                         delay_q;
   logic [CNT_WIDTH-1:0]               len_q;
   logic [CNT_WIDTH-1:0]               bit_cnt_q;
   logic [NCH-1:0][DATA_WIDTH-1:0]     cap_q;
   logic [NCH-1:0][DATA_WIDTH-1:0]     dout_q;
   logic                               valid_q;
   logic                               busy_q;
   logic                               overrun_q;

   logic [CNT_WIDTH-1:0]               len_eff;
   logic [CNT_WIDTH-1:0]               last_idx;
   logic [CNT_WIDTH-1:0]               pos;

   // Effective frame length, index of the last sample and the bit slot of
   // the current sample.
   always_comb begin
      len_eff = len_q;
      if ((len_q == '0) || (len_q > DW_C)) begin
         len_eff = DW_C;
      end
      last_idx = len_eff - CNT_WIDTH'(1);
      if (SHIFT_DIRECTION) begin
         pos = DW_C - CNT_WIDTH'(1) - bit_cnt_q;
      end else begin
         pos = bit_cnt_q;
      end
   end

   // Frame control FSM with capture register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         delay_q   <= '0;
         len_q     <= '0;
         bit_cnt_q <= '0;
         cap_q     <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (start && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  delay_q   <= delay;
                  len_q     <= len;
                  bit_cnt_q <= '0;
                  cap_q     <= '0;
                  overrun_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= (delay != 2'd0) ? S_DELAY : S_SHIFT;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_DELAY: begin
               if (abort) begin
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (delay_q == 2'd1) begin
                  state_q <= S_SHIFT;
               end else begin
                  // The latched delay doubles as the remaining-cycle counter.
                  delay_q <= delay_q - 2'd1;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  for (int unsigned c = 0; c < NCH; c++) begin
                     for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                        if (pos == CNT_WIDTH'(i)) begin
                           cap_q[c][i] <= data_in[c];
                        end
                     end
                  end
                  if (bit_cnt_q != len_eff) begin
                     bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
                  end
                  if (bit_cnt_q == last_idx) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // busy stays high through the valid cycle.
               dout_q  <= cap_q;
               valid_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dout    = dout_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_sr_readback_rx.sv
// Directed bench for sr_readback_rx (DATA_WIDTH=8, NCH=2).
// dut_a captures MSB-first and dut_b captures LSB-first; both share stimulus.
module tb_sr_readback_rx;

   localparam int DW = 8;
   localparam int NC = 2;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [1:0]    delay;
   logic [CW-1:0] len;
   logic [NC-1:0] data_in;

   logic [NC*DW-1:0] dout_a, dout_b;
   logic             valid_a, valid_b;
   logic             busy_a, busy_b;
   logic             ovr_a, ovr_b;
   logic [CW-1:0]    bc_a, bc_b;

   int total = 0;
   int bad   = 0;

   sr_readback_rx #(
      .DATA_WIDTH(DW), .NCH(NC), .CNT_WIDTH(CW), .SHIFT_DIRECTION(1'b1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delay(delay),
      .len(len), .data_in(data_in), .dout(dout_a), .valid(valid_a),
      .busy(busy_a), .overrun(ovr_a), .bit_cnt(bc_a)
   );

   sr_readback_rx #(
      .DATA_WIDTH(DW), .NCH(NC), .CNT_WIDTH(CW), .SHIFT_DIRECTION(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delay(delay),
      .len(len), .data_in(data_in), .dout(dout_b), .valid(valid_b),
      .busy(busy_b), .overrun(ovr_b), .bit_cnt(bc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  d;
      logic [7:0]  l;
      logic [7:0]  s0;   // ch0 stream, first sample at bit 7
      logic [7:0]  s1;   // ch1 stream, first sample at bit 7
      logic [15:0] ea;   // expected dout, MSB-first
      logic [15:0] eb;   // expected dout, LSB-first
      int          lat;  // edges from E0 until valid is seen
      logic [7:0]  bc;   // expected bit_cnt in the valid cycle
   } vec_t;

   vec_t vt[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_frame(input logic [1:0] d, input logic [7:0] l);
      @(posedge clk); #1;
      start = 1'b1; delay = d; len = l; abort = 1'b0; data_in = '0;
      @(posedge clk); #1;   // E0 has just happened
      start = 1'b0;
   endtask

   // Feeds the sample streams after E0 and returns the edge count at which
   // valid was seen (-1 on timeout). Optional start/abort pulses at edge n.
   task automatic frame_body(input logic [1:0] d, input logic [7:0] s0, input logic [7:0] s1,
                             input int ovr_n, input int abt_n, output int lat);
      int k;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         k = n - 1 - int'(d);
         if (k >= 0 && k < 8) data_in = {s1[7-k], s0[7-k]};
         else                 data_in = '0;
         start = (n == ovr_n);
         abort = (n == abt_n);
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         if (n == ovr_n) check("overrun_set", ovr_a, 1);
         if (valid_a) begin
            lat = n;
            break;
         end
         check("busy_in_frame", busy_a, 1);
      end
   endtask

   initial begin
      int lat;
      int vcount;

      vt[0] = '{2'd0, 8'd8,   8'hB2, 8'hFF, 16'hFFB2, 16'hFF4D, 9,  8'd8};
      vt[1] = '{2'd3, 8'd4,   8'hD0, 8'hAF, 16'hA0D0, 16'h050B, 8,  8'd4};
      vt[2] = '{2'd0, 8'd0,   8'h81, 8'h60, 16'h6081, 16'h0681, 9,  8'd8};
      vt[3] = '{2'd1, 8'd200, 8'h1E, 8'h01, 16'h011E, 16'h8078, 10, 8'd8};
      vt[4] = '{2'd2, 8'd1,   8'h80, 8'h00, 16'h0080, 16'h0001, 4,  8'd1};
      vt[5] = '{2'd0, 8'd7,   8'hFF, 8'h55, 16'h54FE, 16'h2A7F, 8,  8'd7};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; delay = '0; len = '0; data_in = '0;
      #12;
      check("rst_dout",    dout_a,  0);
      check("rst_valid",   valid_a, 0);
      check("rst_busy",    busy_a,  0);
      check("rst_overrun", ovr_a,   0);
      check("rst_bit_cnt", bc_a,    0);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         start_frame(vt[i].d, vt[i].l);
         frame_body(vt[i].d, vt[i].s0, vt[i].s1, 0, 0, lat);
         check("latency",      lat,     vt[i].lat);
         check("dout_msb",     dout_a,  vt[i].ea);
         check("dout_lsb",     dout_b,  vt[i].eb);
         check("valid_lsb",    valid_b, 1);
         check("busy_valid",   busy_a,  1);
         check("bit_cnt_sat",  bc_a,    vt[i].bc);
         check("no_overrun",   ovr_a,   0);
         data_in = '0;
         @(posedge clk); #1;
         check("valid_1cycle", valid_a, 0);
         check("busy_after",   busy_a,  0);
         check("dout_hold",    dout_a,  vt[i].ea);
      end

      // Overrun during SHIFT, then a start in the valid cycle
      start_frame(2'd0, 8'd8);
      frame_body(2'd0, 8'hB2, 8'hFF, 3, 0, lat);
      check("ovr_latency",  lat,    9);
      check("ovr_dout_msb", dout_a, 16'hFFB2);
      check("ovr_dout_lsb", dout_b, 16'hFF4D);
      check("ovr_sticky",   ovr_a,  1);
      start = 1'b1; delay = 2'd0; len = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_valid_low",   valid_a, 0);
      check("b2b_ovr_cleared", ovr_a,   0);
      check("b2b_busy",        busy_a,  1);
      frame_body(2'd0, 8'hF0, 8'h00, 0, 0, lat);
      check("b2b_latency",  lat,    5);
      check("b2b_dout_msb", dout_a, 16'h00F0);
      check("b2b_dout_lsb", dout_b, 16'h000F);

      // abort while in DONE is ignored
      start_frame(2'd0, 8'd2);
      frame_body(2'd0, 8'hC0, 8'h40, 0, 3, lat);
      check("done_abort_latency",  lat,    3);
      check("done_abort_dout_msb", dout_a, 16'h40C0);
      check("done_abort_dout_lsb", dout_b, 16'h0203);
      @(posedge clk); #1;

      // abort mid-SHIFT
      start_frame(2'd0, 8'd8);
      for (int n = 1; n <= 4; n++) begin
         data_in = 2'b11;
         @(posedge clk); #1;
      end
      check("abort_pre_bit_cnt", bc_a,   4);
      check("abort_pre_busy",    busy_a, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy",    busy_a,  0);
      check("abort_bit_cnt", bc_a,    0);
      check("abort_valid",   valid_a, 0);
      vcount = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (valid_a) vcount++;
      end
      check("abort_no_valid", vcount, 0);
      check("abort_dout",     dout_a, 16'h40C0);

      // Asynchronous reset mid-SHIFT
      start_frame(2'd0, 8'd8);
      data_in = 2'b11;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("pre_rst_overrun", ovr_a, 1);
      @(posedge clk); #1;
      check("pre_rst_bit_cnt", bc_a, 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dout",    dout_a,  0);
      check("arst_valid",   valid_a, 0);
      check("arst_busy",    busy_a,  0);
      check("arst_overrun", ovr_a,   0);
      check("arst_bit_cnt", bc_a,    0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      start_frame(2'd1, 8'd8);
      frame_body(2'd1, 8'h3C, 8'h81, 0, 0, lat);
      check("post_rst_latency",  lat,    10);
      check("post_rst_dout_msb", dout_a, 16'h813C);
      check("post_rst_dout_lsb", dout_b, 16'h813C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
